// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side hazard inputs and slot/stall outputs of pipe_hazard_ctrl, bundled as one interface.
// The controller connects through the slave modport and the decode/datapath side through master.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             DE_valid;
    logic [4:0]       DE_rs1;
    logic [4:0]       DE_rs2;
    logic [4:0]       DE_rd;
    logic             DE_RegWrite;
    logic             DE_MemRead;
    logic             DE_MemWrite;
    logic             EX_branch_taken;
    logic             dmem_ready;

    logic [4:0]       DE_EX_rs1;
    logic [4:0]       DE_EX_rs2;
    logic [4:0]       EX_MEM_rd;
    logic [4:0]       MEM_WB_rd;
    logic             EX_MEM_RegWrite;
    logic             MEM_WB_RegWrite;
    logic             stall_FD;
    logic             flush_FD;
    logic             freeze;
    logic [1:0]       pipe_state;
    logic [CNT_W-1:0] lu_stall_cnt;
    logic [CNT_W-1:0] mem_stall_cnt;

    modport master (
        output DE_valid, DE_rs1, DE_rs2, DE_rd,
        output DE_RegWrite, DE_MemRead, DE_MemWrite,
        output EX_branch_taken, dmem_ready,
        input  DE_EX_rs1, DE_EX_rs2, EX_MEM_rd, MEM_WB_rd,
        input  EX_MEM_RegWrite, MEM_WB_RegWrite,
        input  stall_FD, flush_FD, freeze, pipe_state,
        input  lu_stall_cnt, mem_stall_cnt
    );

    modport slave (
        input  DE_valid, DE_rs1, DE_rs2, DE_rd,
        input  DE_RegWrite, DE_MemRead, DE_MemWrite,
        input  EX_branch_taken, dmem_ready,
        output DE_EX_rs1, DE_EX_rs2, EX_MEM_rd, MEM_WB_rd,
        output EX_MEM_RegWrite, MEM_WB_RegWrite,
        output stall_FD, flush_FD, freeze, pipe_state,
        output lu_stall_cnt, mem_stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline hazard controller: load-use stall, taken-branch flush, data-memory wait freeze.
// Define HAZARD_PERF_CNT_EN to build the saturating stall-cycle performance counters.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic               CLK,
    input  logic               RST_N,
    pipe_hazard_ctrl_if.slave  hz
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
    } slot_t;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_STALL = 2'b01,
        MEM_WAIT = 2'b10
    } state_t;

    localparam slot_t BUBBLE = '0;

    slot_t  de_ex_reg, ex_mem_reg, mem_wb_reg;
    slot_t  de_ex_next, ex_mem_next, mem_wb_next;
    slot_t  de_in;
    state_t state_reg, state_next;

    logic mem_busy;
    logic load_use;
    logic branch;
    logic lu_event;
    logic stall_fd;
    logic flush_fd;
    logic freeze_int;

    // Control bits of an invalid decode slot are dropped so bubbles never write.
    always_comb begin
        de_in           = BUBBLE;
        de_in.valid     = hz.DE_valid;
        de_in.rs1       = hz.DE_rs1;
        de_in.rs2       = hz.DE_rs2;
        de_in.rd        = hz.DE_rd;
        de_in.reg_write = hz.DE_RegWrite & hz.DE_valid;
        de_in.mem_read  = hz.DE_MemRead  & hz.DE_valid;
        de_in.mem_write = hz.DE_MemWrite & hz.DE_valid;
    end

    assign mem_busy = ex_mem_reg.valid
                    & (ex_mem_reg.mem_read | ex_mem_reg.mem_write)
                    & ~hz.dmem_ready;

    assign load_use = hz.DE_valid & de_ex_reg.valid & de_ex_reg.mem_read
                    & (de_ex_reg.rd != 5'd0)
                    & ((de_ex_reg.rd == hz.DE_rs1) | (de_ex_reg.rd == hz.DE_rs2));

    // A branch under a memory wait is held in EX and only acts once memory completes.
    assign branch   = hz.EX_branch_taken & ~mem_busy;
    assign lu_event = load_use & ~hz.EX_branch_taken & ~mem_busy;

    always_comb begin
        de_ex_next  = de_ex_reg;
        ex_mem_next = ex_mem_reg;
        mem_wb_next = mem_wb_reg;
        if (!mem_busy) begin
            mem_wb_next = ex_mem_reg;
            ex_mem_next = de_ex_reg;
            de_ex_next  = (branch || load_use) ? BUBBLE : de_in;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            de_ex_reg  <= BUBBLE;
            ex_mem_reg <= BUBBLE;
            mem_wb_reg <= BUBBLE;
        end else begin
            de_ex_reg  <= de_ex_next;
            ex_mem_reg <= ex_mem_next;
            mem_wb_reg <= mem_wb_next;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = RUN;
        if (mem_busy) begin
            state_next = MEM_WAIT;
        end else if (lu_event) begin
            state_next = LU_STALL;
        end
    end

    // Stall/flush/freeze are forced low while reset is asserted, whatever the inputs do.
    always_comb begin
        stall_fd   = 1'b0;
        flush_fd   = 1'b0;
        freeze_int = 1'b0;
        if (RST_N) begin
            freeze_int = mem_busy;
            stall_fd   = mem_busy | lu_event;
            flush_fd   = branch;
        end
    end

    assign hz.stall_FD        = stall_fd;
    assign hz.flush_FD        = flush_fd;
    assign hz.freeze          = freeze_int;
    assign hz.pipe_state      = state_reg;
    assign hz.DE_EX_rs1       = de_ex_reg.rs1;
    assign hz.DE_EX_rs2       = de_ex_reg.rs2;
    assign hz.EX_MEM_rd       = ex_mem_reg.rd;
    assign hz.EX_MEM_RegWrite = ex_mem_reg.reg_write;
    assign hz.MEM_WB_rd       = mem_wb_reg.rd;
    assign hz.MEM_WB_RegWrite = mem_wb_reg.reg_write;

    logic slot_fields_unused;
    assign slot_fields_unused = ^{ex_mem_reg.rs1, ex_mem_reg.rs2,
                                  mem_wb_reg.valid, mem_wb_reg.rs1, mem_wb_reg.rs2,
                                  mem_wb_reg.mem_read, mem_wb_reg.mem_write};

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] lu_cnt_reg, mem_cnt_reg;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lu_cnt_reg  <= '0;
            mem_cnt_reg <= '0;
        end else begin
            if (lu_event && !(&lu_cnt_reg)) begin
                lu_cnt_reg <= lu_cnt_reg + 1'b1;
            end
            if (mem_busy && !(&mem_cnt_reg)) begin
                mem_cnt_reg <= mem_cnt_reg + 1'b1;
            end
        end
    end

    assign hz.lu_stall_cnt  = lu_cnt_reg;
    assign hz.mem_stall_cnt = mem_cnt_reg;
`else
    assign hz.lu_stall_cnt  = '0;
    assign hz.mem_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl: load-use, x0, memory wait, branch priority, async reset.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(32)) hz ();

    pipe_hazard_ctrl #(.CNT_W(32)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .hz    (hz.slave)
    );

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef enum int {
        S_STALL, S_FLUSH, S_FREEZE, S_STATE,
        S_DEEX_RS1, S_DEEX_RS2, S_EXMEM_RD, S_EXMEM_RW,
        S_MEMWB_RD, S_MEMWB_RW, S_LUCNT, S_MEMCNT
    } sig_t;

    typedef struct {
        string       tag;
        sig_t        sig;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic logic [31:0] observe(sig_t s);
        case (s)
            S_STALL:    observe = {31'd0, hz.stall_FD};
            S_FLUSH:    observe = {31'd0, hz.flush_FD};
            S_FREEZE:   observe = {31'd0, hz.freeze};
            S_STATE:    observe = {30'd0, hz.pipe_state};
            S_DEEX_RS1: observe = {27'd0, hz.DE_EX_rs1};
            S_DEEX_RS2: observe = {27'd0, hz.DE_EX_rs2};
            S_EXMEM_RD: observe = {27'd0, hz.EX_MEM_rd};
            S_EXMEM_RW: observe = {31'd0, hz.EX_MEM_RegWrite};
            S_MEMWB_RD: observe = {27'd0, hz.MEM_WB_rd};
            S_MEMWB_RW: observe = {31'd0, hz.MEM_WB_RegWrite};
            S_LUCNT:    observe = hz.lu_stall_cnt;
            S_MEMCNT:   observe = hz.mem_stall_cnt;
            default:    observe = 'x;
        endcase
    endfunction

    function automatic logic [31:0] cnt(int n);
        cnt = PERF ? 32'(n) : 32'd0;
    endfunction

    task automatic exp_push(string tag, sig_t s, logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sig = s;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sig);
            vectors++;
            assert (obs === e.val) else begin
                miscompares++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
            $display("vec %0d %s observed=%0h expected=%0h", vectors, e.tag, obs, e.val);
        end
    endtask

    task automatic drive_de(logic v, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                            logic rw, logic mr, logic mw);
        hz.DE_valid    = v;
        hz.DE_rs1      = rs1;
        hz.DE_rs2      = rs2;
        hz.DE_rd       = rd;
        hz.DE_RegWrite = rw;
        hz.DE_MemRead  = mr;
        hz.DE_MemWrite = mw;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic settle_check();
        #1;
        check_all();
    endtask

    initial begin
        // Reset held with hostile inputs: everything must read zero.
        rst_n = 1'b0;
        drive_de(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0);
        hz.EX_branch_taken = 1'b1;
        hz.dmem_ready      = 1'b0;
        #12;
        exp_push("rst_stall",  S_STALL,    0);
        exp_push("rst_flush",  S_FLUSH,    0);
        exp_push("rst_freeze", S_FREEZE,   0);
        exp_push("rst_state",  S_STATE,    0);
        exp_push("rst_exmemrw",S_EXMEM_RW, 0);
        exp_push("rst_deexrs1",S_DEEX_RS1, 0);
        exp_push("rst_lucnt",  S_LUCNT,    0);
        exp_push("rst_memcnt", S_MEMCNT,   0);
        check_all();

        // A: lw x5 enters decode
        next_cycle();
        rst_n = 1'b1;
        hz.EX_branch_taken = 1'b0;
        hz.dmem_ready      = 1'b1;
        drive_de(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
        exp_push("A_stall", S_STALL, 0);
        settle_check();

        // B: add x6,x5,x7 behind the load -> load-use stall
        next_cycle();
        drive_de(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b0, 1'b0);
        exp_push("B_lu_stall",  S_STALL,    1);
        exp_push("B_lu_flush",  S_FLUSH,    0);
        exp_push("B_lu_freeze", S_FREEZE,   0);
        exp_push("B_deex_rs1",  S_DEEX_RS1, 1);
        exp_push("B_state",     S_STATE,    0);
        settle_check();

        // C: stall lasts one cycle, load moved to EX/MEM
        next_cycle();
        exp_push("C_stall",      S_STALL,    0);
        exp_push("C_exmem_rd",   S_EXMEM_RD, 5);
        exp_push("C_exmem_rw",   S_EXMEM_RW, 1);
        exp_push("C_state_lu",   S_STATE,    1);
        exp_push("C_deex_bub",   S_DEEX_RS1, 0);
        exp_push("C_lucnt",      S_LUCNT,    cnt(1));
        settle_check();

        // D: dependent add now in DE/EX, bubble in EX/MEM
        next_cycle();
        drive_de(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        exp_push("D_deex_rs1",  S_DEEX_RS1, 5);
        exp_push("D_deex_rs2",  S_DEEX_RS2, 7);
        exp_push("D_exmem_bub", S_EXMEM_RW, 0);
        exp_push("D_memwb_rd",  S_MEMWB_RD, 5);
        exp_push("D_memwb_rw",  S_MEMWB_RW, 1);
        exp_push("D_state",     S_STATE,    0);
        settle_check();

        // E: lw x0
        next_cycle();
        drive_de(1'b1, 5'd2, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        exp_push("E_exmem_rd", S_EXMEM_RD, 6);
        exp_push("E_exmem_rw", S_EXMEM_RW, 1);
        exp_push("E_memwb_rw", S_MEMWB_RW, 0);
        settle_check();

        // F: store with rs2=0 behind lw x0 -> no stall
        next_cycle();
        drive_de(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        exp_push("F_x0_stall", S_STALL,    0);
        exp_push("F_state",    S_STATE,    0);
        exp_push("F_memwb_rd", S_MEMWB_RD, 6);
        exp_push("F_deex_rs1", S_DEEX_RS1, 2);
        settle_check();

        // G..I: lw x0 in EX/MEM waits three cycles on memory
        next_cycle();
        hz.dmem_ready = 1'b0;
        drive_de(1'b1, 5'd4, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);
        exp_push("G_freeze",   S_FREEZE,   1);
        exp_push("G_stall",    S_STALL,    1);
        exp_push("G_flush",    S_FLUSH,    0);
        exp_push("G_state",    S_STATE,    0);
        exp_push("G_exmem_rd", S_EXMEM_RD, 0);
        exp_push("G_deex_rs1", S_DEEX_RS1, 3);
        settle_check();

        next_cycle();
        exp_push("H_freeze",   S_FREEZE,   1);
        exp_push("H_state",    S_STATE,    2);
        exp_push("H_deex_rs1", S_DEEX_RS1, 3);
        exp_push("H_memcnt",   S_MEMCNT,   cnt(1));
        settle_check();

        next_cycle();
        exp_push("I_freeze", S_FREEZE, 1);
        exp_push("I_state",  S_STATE,  2);
        exp_push("I_memcnt", S_MEMCNT, cnt(2));
        settle_check();

        // J: memory completes
        next_cycle();
        hz.dmem_ready = 1'b1;
        exp_push("J_freeze",   S_FREEZE,   0);
        exp_push("J_stall",    S_STALL,    0);
        exp_push("J_state",    S_STATE,    2);
        exp_push("J_memcnt",   S_MEMCNT,   cnt(3));
        exp_push("J_deex_rs1", S_DEEX_RS1, 3);
        settle_check();

        next_cycle();
        drive_de(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        exp_push("K_deex_rs1", S_DEEX_RS1, 4);
        exp_push("K_state",    S_STATE,    0);
        exp_push("K_memcnt",   S_MEMCNT,   cnt(3));
        exp_push("K_memwb_rd", S_MEMWB_RD, 0);
        exp_push("K_exmem_rw", S_EXMEM_RW, 0);
        settle_check();

        // L/M: branch coincides with load-use -> flush wins
        next_cycle();
        drive_de(1'b1, 5'd1, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0);
        exp_push("L_stall",    S_STALL,    0);
        exp_push("L_exmem_rd", S_EXMEM_RD, 8);
        settle_check();

        next_cycle();
        drive_de(1'b1, 5'd9, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0);
        hz.EX_branch_taken = 1'b1;
        exp_push("M_br_flush",  S_FLUSH,  1);
        exp_push("M_br_stall",  S_STALL,  0);
        exp_push("M_br_freeze", S_FREEZE, 0);
        exp_push("M_lucnt",     S_LUCNT,  cnt(1));
        settle_check();

        next_cycle();
        hz.EX_branch_taken = 1'b0;
        drive_de(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        exp_push("N_state",    S_STATE,    0);
        exp_push("N_lucnt",    S_LUCNT,    cnt(1));
        exp_push("N_deex_bub", S_DEEX_RS1, 0);
        exp_push("N_exmem_rd", S_EXMEM_RD, 9);
        exp_push("N_stall",    S_STALL,    0);
        settle_check();

        // O..S: branch raised while memory is busy
        next_cycle();
        drive_de(1'b1, 5'd2, 5'd0, 5'd11, 1'b1, 1'b1, 1'b0);
        exp_push("O_stall", S_STALL, 0);
        settle_check();

        next_cycle();
        drive_de(1'b1, 5'd1, 5'd3, 5'd12, 1'b1, 1'b0, 1'b0);
        exp_push("P_stall",    S_STALL,    0);
        exp_push("P_deex_rs1", S_DEEX_RS1, 2);
        settle_check();

        next_cycle();
        hz.dmem_ready      = 1'b0;
        hz.EX_branch_taken = 1'b1;
        drive_de(1'b1, 5'd4, 5'd0, 5'd13, 1'b1, 1'b0, 1'b0);
        exp_push("Q_mb_flush",  S_FLUSH,    0);
        exp_push("Q_mb_freeze", S_FREEZE,   1);
        exp_push("Q_mb_stall",  S_STALL,    1);
        exp_push("Q_exmem_rd",  S_EXMEM_RD, 11);
        settle_check();

        next_cycle();
        hz.dmem_ready = 1'b1;
        exp_push("R_flush",    S_FLUSH,    1);
        exp_push("R_stall",    S_STALL,    0);
        exp_push("R_freeze",   S_FREEZE,   0);
        exp_push("R_state",    S_STATE,    2);
        exp_push("R_deex_rs1", S_DEEX_RS1, 1);
        settle_check();

        next_cycle();
        hz.EX_branch_taken = 1'b0;
        drive_de(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        exp_push("S_deex_bub", S_DEEX_RS1, 0);
        exp_push("S_exmem_rd", S_EXMEM_RD, 12);
        exp_push("S_memwb_rd", S_MEMWB_RD, 11);
        exp_push("S_state",    S_STATE,    0);
        exp_push("S_memcnt",   S_MEMCNT,   cnt(4));
        settle_check();

        // T..W: enter MEM_WAIT, then assert reset asynchronously mid-cycle
        next_cycle();
        drive_de(1'b1, 5'd0, 5'd0, 5'd14, 1'b1, 1'b1, 1'b0);
        exp_push("T_stall", S_STALL, 0);
        settle_check();

        next_cycle();
        drive_de(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        exp_push("U_freeze", S_FREEZE, 0);
        settle_check();

        next_cycle();
        hz.dmem_ready      = 1'b0;
        hz.EX_branch_taken = 1'b1;
        exp_push("V_freeze",   S_FREEZE,   1);
        exp_push("V_flush",    S_FLUSH,    0);
        exp_push("V_exmem_rd", S_EXMEM_RD, 14);
        settle_check();

        next_cycle();
        exp_push("W_state",  S_STATE,  2);
        exp_push("W_freeze", S_FREEZE, 1);
        settle_check();

        #2;
        rst_n = 1'b0;
        exp_push("W_arst_stall",   S_STALL,    0);
        exp_push("W_arst_flush",   S_FLUSH,    0);
        exp_push("W_arst_freeze",  S_FREEZE,   0);
        exp_push("W_arst_state",   S_STATE,    0);
        exp_push("W_arst_deexrs1", S_DEEX_RS1, 0);
        exp_push("W_arst_exmemrd", S_EXMEM_RD, 0);
        exp_push("W_arst_exmemrw", S_EXMEM_RW, 0);
        exp_push("W_arst_memwbrd", S_MEMWB_RD, 0);
        exp_push("W_arst_memwbrw", S_MEMWB_RW, 0);
        exp_push("W_arst_lucnt",   S_LUCNT,    0);
        exp_push("W_arst_memcnt",  S_MEMCNT,   0);
        settle_check();

        // X: release reset with memory still not ready -> empty pipe, no stale freeze
        next_cycle();
        next_cycle();
        rst_n              = 1'b1;
        hz.EX_branch_taken = 1'b0;
        exp_push("X_freeze",   S_FREEZE,   0);
        exp_push("X_stall",    S_STALL,    0);
        exp_push("X_state",    S_STATE,    0);
        exp_push("X_exmem_rw", S_EXMEM_RW, 0);
        settle_check();

        next_cycle();
        exp_push("Y_state",  S_STATE,  0);
        exp_push("Y_freeze", S_FREEZE, 0);
        settle_check();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
